uart_hs_serdes: RTL and testbench

Serial engine for the UART path: converts bytes to and from 8N1 serial frames on `uart_txd`/`uart_rxd`. It exchanges bytes with the bus-side UART wrapper over two 4-phase req/ack handshakes. The block runs entirely on `sys_clk` (50 MHz). Because the wrapper sits on a different clock, every handshake input is synchronised here.

---
 rtl/uart_hs_serdes.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_uart_hs_serdes.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_hs_serdes.sv
// 8N1 serial engine with 4-phase req/ack byte handshakes, all logic on sys_clk.
// Optional macro UART_HS_RX_HOLD_EN adds a one-byte RX holding register for overrun absorption.
//
// TX state | meaning
// TX_IDLE  | line high, waiting for a synchronised send request
// TX_START | start bit (low) for DIV cycles
// TX_DATA  | 8 data bits, LSB first, DIV cycles each
// TX_STOP  | stop bit (high) for DIV cycles
// TX_ACK   | send_ack held until the request is withdrawn
//
// RX state | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | half-bit wait, then start-bit validation
// RX_DATA  | 8 centre samples, LSB first
// RX_STOP  | stop-bit centre sample
// RX_BREAK | framing error, waiting for the line to return high

module uart_hs_serdes #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic       uart_rec_req,
   input  logic       uart_rec_ack,
   output logic [7:0] uart_data_out,
   input  logic       uart_send_req,
   output logic       uart_send_ack,
   input  logic [7:0] uart_data_in
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_ACK} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
   typedef enum logic [1:0] {DLV_NONE, DLV_REQ, DLV_WAIT} dlv_state_t;

   logic [1:0] rxd_sync_q, sreq_sync_q, rack_sync_q;
   logic       rxd_prev_q;
   logic       rxd_s, sreq_s, rack_s, rxd_fall;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_sync_q  <= 2'b11;
         sreq_sync_q <= 2'b00;
         rack_sync_q <= 2'b00;
         rxd_prev_q  <= 1'b1;
      end else begin
         rxd_sync_q  <= {rxd_sync_q[0], uart_rxd};
         sreq_sync_q <= {sreq_sync_q[0], uart_send_req};
         rack_sync_q <= {rack_sync_q[0], uart_rec_ack};
         rxd_prev_q  <= rxd_s;
      end
   end

   assign rxd_s    = rxd_sync_q[1];
   assign sreq_s   = sreq_sync_q[1];
   assign rack_s   = rack_sync_q[1];
   assign rxd_fall = rxd_prev_q & ~rxd_s;

   // ---------------- transmitter ----------------
   tx_state_t     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          txd_q, txd_d, sack_q, sack_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
         sack_q     <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         sack_q     <= sack_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (sreq_s && !sack_q) begin
               tx_shift_d = uart_data_in;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
               else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_ACK;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_ACK:  if (!sreq_s) tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Ack drops in the same cycle the FSM leaves TX_ACK, giving 3-cycle release.
   always_comb begin
      txd_d  = 1'b1;
      sack_d = 1'b0;
      case (tx_state_q)
         TX_START: txd_d  = 1'b0;
         TX_DATA:  txd_d  = tx_shift_q[0];
         TX_ACK:   sack_d = sreq_s;
         default:  txd_d  = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_done;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            if (rxd_fall) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_s, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = rxd_s ? RX_IDLE : RX_BREAK;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_BREAK: if (rxd_s) rx_state_d = RX_IDLE;
         default:  rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_done = (rx_state_q == RX_STOP) && (rx_cnt_q == CNT_LAST) && rxd_s;
   end

   // ---------------- delivery handshake ----------------
   dlv_state_t dlv_q, dlv_d;
   logic       req_q, req_d;
   logic [7:0] dout_q, dout_d;
   logic       take_rx;
`ifdef UART_HS_RX_HOLD_EN
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   assign take_rx = rx_done && (dlv_q == DLV_NONE) && !hold_full_q;
`else
   assign take_rx = rx_done && (dlv_q == DLV_NONE);
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dlv_q  <= DLV_NONE;
         req_q  <= 1'b0;
         dout_q <= '0;
      end else begin
         dlv_q  <= dlv_d;
         req_q  <= req_d;
         dout_q <= dout_d;
      end
   end

   always_comb begin
      dlv_d  = dlv_q;
      req_d  = req_q;
      dout_d = dout_q;
`ifdef UART_HS_RX_HOLD_EN
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`endif
      case (dlv_q)
         DLV_NONE: begin
`ifdef UART_HS_RX_HOLD_EN
            if (hold_full_q) begin
               dout_d      = hold_q;
               req_d       = 1'b1;
               dlv_d       = DLV_REQ;
               hold_full_d = 1'b0;
            end else
`endif
            if (take_rx) begin
               dout_d = rx_shift_q;
               req_d  = 1'b1;
               dlv_d  = DLV_REQ;
            end
         end
         DLV_REQ: begin
            if (rack_s) begin
               req_d = 1'b0;
               dlv_d = DLV_WAIT;
            end
         end
         DLV_WAIT: if (!rack_s) dlv_d = DLV_NONE;
         default:  dlv_d = DLV_NONE;
      endcase
`ifdef UART_HS_RX_HOLD_EN
      // A full hold is only refilled when it is being emptied this cycle; otherwise the newest byte is lost.
      if (rx_done && !take_rx && (!hold_full_q || dlv_q == DLV_NONE)) begin
         hold_d      = rx_shift_q;
         hold_full_d = 1'b1;
      end
`endif
   end

   assign uart_txd      = txd_q;
   assign uart_send_ack = sack_q;
   assign uart_rec_req  = req_q;
   assign uart_data_out = dout_q;

endmodule

// File: tb/tb_uart_hs_serdes.sv
// Directed bench for uart_hs_serdes: TX frame timing, RX vectors, glitch, duplex, overrun, reset.
module tb_uart_hs_serdes;

   localparam int DIV = 434;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd = 1'b1;
   logic       txd;
   logic       rec_req;
   logic       rec_ack = 1'b0;
   logic [7:0] dout;
   logic       send_req = 1'b0;
   logic       send_ack;
   logic [7:0] din = 8'h00;

   int checks = 0;
   int errors = 0;

   uart_hs_serdes #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
      .sys_clk      (clk),
      .sys_rst_n    (rst_n),
      .uart_rxd     (rxd),
      .uart_txd     (txd),
      .uart_rec_req (rec_req),
      .uart_rec_ack (rec_ack),
      .uart_data_out(dout),
      .uart_send_req(send_req),
      .uart_send_ack(send_ack),
      .uart_data_in (din)
   );

   always #10 clk = ~clk;

   typedef struct {
      int   cyc;
      logic txd;
      logic ack;
   } tx_vec_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_req;
      logic [7:0] exp_dout;
   } rx_vec_t;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Send one byte and walk its frame; cycle 0 is the negedge where the request is raised.
   task automatic run_tx(input logic [7:0] b);
      tx_vec_t tv[$];
      logic    fb;
      int      k;
      tv.push_back('{3, 1'b1, 1'b0});
      tv.push_back('{4, 1'b0, 1'b0});
      tv.push_back('{4 + DIV/2, 1'b0, 1'b0});
      tv.push_back('{3 + DIV, 1'b0, 1'b0});
      tv.push_back('{4 + DIV, b[0], 1'b0});
      for (int j = 1; j < 10; j++) begin
         fb = (j == 9) ? 1'b1 : b[j-1];
         tv.push_back('{4 + DIV*j + DIV/2, fb, 1'b0});
      end
      tv.push_back('{3 + 10*DIV, 1'b1, 1'b0});
      tv.push_back('{4 + 10*DIV, 1'b1, 1'b1});
      din = b;
      send_req = 1'b1;
      k = 0;
      foreach (tv[i]) begin
         cyc(tv[i].cyc - k);
         k = tv[i].cyc;
         chk($sformatf("tx_txd@%0d", k), {31'd0, txd}, {31'd0, tv[i].txd});
         chk($sformatf("tx_ack@%0d", k), {31'd0, send_ack}, {31'd0, tv[i].ack});
      end
      send_req = 1'b0;
      cyc(2);
      chk("tx_ack_hold", {31'd0, send_ack}, 32'd1);
      cyc(1);
      chk("tx_ack_release", {31'd0, send_ack}, 32'd0);
      cyc(10);
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      cyc(DIV);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         cyc(DIV);
      end
      rxd = stop;
      cyc(DIV);
      rxd = 1'b1;
   endtask

   task automatic rx_handshake(input string name);
      rec_ack = 1'b1;
      cyc(2);
      chk({name, "_req_hold"}, {31'd0, rec_req}, 32'd1);
      cyc(1);
      chk({name, "_req_release"}, {31'd0, rec_req}, 32'd0);
      rec_ack = 1'b0;
      cyc(10);
   endtask

   rx_vec_t rv[4];

   initial begin
      rv[0] = '{8'hA3, 1'b1, 1'b1, 8'hA3};
      rv[1] = '{8'h5C, 1'b0, 1'b0, 8'hA3};
      rv[2] = '{8'h00, 1'b1, 1'b1, 8'h00};
      rv[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF};

      cyc(3);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_ack", {31'd0, send_ack}, 32'd0);
      chk("rst_req", {31'd0, rec_req}, 32'd0);
      chk("rst_dout", {24'd0, dout}, 32'd0);
      rst_n = 1'b1;
      cyc(5);

      run_tx(8'h55);

      foreach (rv[i]) begin
         drive_frame(rv[i].data, rv[i].stop);
         cyc(20);
         chk($sformatf("rx%0d_req", i), {31'd0, rec_req}, {31'd0, rv[i].exp_req});
         chk($sformatf("rx%0d_dout", i), {24'd0, dout}, {24'd0, rv[i].exp_dout});
         if (rv[i].exp_req) rx_handshake($sformatf("rx%0d", i));
         else cyc(50);
      end

      // Short low pulse must be rejected as a glitch.
      rxd = 1'b0;
      cyc(100);
      rxd = 1'b1;
      cyc(600);
      chk("glitch_req", {31'd0, rec_req}, 32'd0);
      chk("glitch_dout", {24'd0, dout}, 32'd255);

      fork
         run_tx(8'h0F);
         begin
            cyc(1000);
            drive_frame(8'hF0, 1'b1);
         end
      join
      cyc(20);
      chk("dup_req", {31'd0, rec_req}, 32'd1);
      chk("dup_dout", {24'd0, dout}, 32'hF0);
      rx_handshake("dup");

      drive_frame(8'h11, 1'b1);
      drive_frame(8'h22, 1'b1);
      drive_frame(8'h33, 1'b1);
      cyc(50);
      chk("ovr_req1", {31'd0, rec_req}, 32'd1);
      chk("ovr_dout1", {24'd0, dout}, 32'h11);
      rx_handshake("ovr1");
`ifdef UART_HS_RX_HOLD_EN
      chk("ovr_req2", {31'd0, rec_req}, 32'd1);
      chk("ovr_dout2", {24'd0, dout}, 32'h22);
      rx_handshake("ovr2");
      cyc(100);
      chk("ovr_no3", {31'd0, rec_req}, 32'd0);
      chk("ovr_dout_kept", {24'd0, dout}, 32'h22);
`else
      cyc(100);
      chk("ovr_no2", {31'd0, rec_req}, 32'd0);
      chk("ovr_dout_kept", {24'd0, dout}, 32'h11);
`endif

      // Reset during bit 3 of 0xFF.
      din = 8'hFF;
      send_req = 1'b1;
      cyc(4 + DIV*4 + 100);
      rst_n = 1'b0;
      send_req = 1'b0;
      #1;
      chk("rst_mid_txd", {31'd0, txd}, 32'd1);
      chk("rst_mid_req", {31'd0, rec_req}, 32'd0);
      chk("rst_mid_dout", {24'd0, dout}, 32'd0);
      cyc(3);
      rst_n = 1'b1;
      cyc(12 * DIV);
      chk("rst_mid_ack", {31'd0, send_ack}, 32'd0);
      chk("rst_mid_idle", {31'd0, txd}, 32'd1);

      // Reset while the line is driven low must release it at once.
      din = 8'h00;
      send_req = 1'b1;
      cyc(100);
      chk("rst_start_low", {31'd0, txd}, 32'd0);
      rst_n = 1'b0;
      send_req = 1'b0;
      #1;
      chk("rst_start_txd", {31'd0, txd}, 32'd1);
      cyc(3);
      rst_n = 1'b1;
      cyc(12 * DIV);
      chk("rst_start_ack", {31'd0, send_ack}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
